// File: rtl/sweep_sched.sv
// sweep_sched: DDS direct-mode frequency sweep sequencer (load, hold enable, settle, measure, step).
// Outputs are registered decodes of the current state, so each strobe trails its state by one cycle.
module sweep_sched #(
   parameter int EN_HOLD  = 4,
   parameter int SETTLE_W = 24
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                cfg_wen,
   input  logic [31:0]         cfg_start_fword,
   input  logic [31:0]         cfg_step_fword,
   input  logic [15:0]         cfg_points,
   input  logic [31:0]         cfg_pword,
   input  logic [31:0]         cfg_amp,
   input  logic [SETTLE_W-1:0] cfg_settle,
   input  logic                start,
   input  logic                abort,
   input  logic                meas_done,
   output logic                param_wen,
   output logic [31:0]         direct_fword,
   output logic [31:0]         direct_pword,
   output logic [31:0]         direct_amp,
   output logic                direct_en,
   output logic                meas_start,
   output logic [15:0]         point_idx,
   output logic                busy,
   output logic                done
);
   typedef enum logic [2:0] {IDLE, LOAD, APPLY, SETTLE, MEASURE, NEXT} state_t;
   state_t state;
   logic [31:0] sh_start, sh_step, sh_pword, sh_amp, fword;
   logic [15:0] sh_points;
   logic [SETTLE_W-1:0] sh_settle, cnt;
   logic first, cap, last;
   logic [31:0] e_start;
   logic [15:0] e_points;
   // a cfg_wen coinciding with start is already visible to that sweep
   assign cap      = state == IDLE && cfg_wen;
   assign e_start  = cap ? cfg_start_fword : sh_start;
   assign e_points = cap ? cfg_points : sh_points;
   assign last     = point_idx == sh_points - 16'd1;
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
         sh_start <= '0;
         sh_step <= '0;
         sh_pword <= '0;
         sh_amp <= '0;
         sh_points <= '0;
         sh_settle <= '0;
         fword <= '0;
         cnt <= '0;
         first <= 1'b0;
         param_wen <= 1'b0;
         direct_fword <= '0;
         direct_pword <= '0;
         direct_amp <= '0;
         direct_en <= 1'b0;
         meas_start <= 1'b0;
         point_idx <= '0;
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         if (cap) begin
            sh_start <= cfg_start_fword;
            sh_step <= cfg_step_fword;
            sh_pword <= cfg_pword;
            sh_amp <= cfg_amp;
            sh_points <= cfg_points;
            sh_settle <= cfg_settle;
         end
         param_wen <= !abort && state == LOAD;
         direct_en <= !abort && state == APPLY;
         meas_start <= !abort && state == MEASURE && first;
         done <= !abort && (state == NEXT ? last : state == IDLE && start && e_points == '0);
         first <= 1'b0;
         if (abort) begin
            state <= IDLE;
            busy <= 1'b0;
         end else begin
            case (state)
               IDLE: if (start) begin
                  point_idx <= '0;
                  if (e_points != '0) begin
                     state <= LOAD;
                     busy <= 1'b1;
                     fword <= e_start;
                  end
               end
               LOAD: begin
                  state <= APPLY;
                  cnt <= SETTLE_W'(EN_HOLD - 1);
                  direct_fword <= fword;
                  direct_pword <= sh_pword;
                  direct_amp <= sh_amp;
               end
               APPLY: if (cnt != '0) cnt <= cnt - 1'b1;
                  else if (sh_settle == '0) begin
                     state <= MEASURE;
                     first <= 1'b1;
                  end else begin
                     state <= SETTLE;
                     cnt <= sh_settle - 1'b1;
                  end
               SETTLE: if (cnt != '0) cnt <= cnt - 1'b1;
                  else begin
                     state <= MEASURE;
                     first <= 1'b1;
                  end
               // completion is only accepted once the trigger cycle has passed
               MEASURE: if (!first && !meas_start && meas_done) state <= NEXT;
               NEXT: if (last) begin
                  state <= IDLE;
                  busy <= 1'b0;
               end else begin
                  state <= LOAD;
                  point_idx <= point_idx + 16'd1;
                  fword <= fword + sh_step;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_sweep_sched.sv
// tb_sweep_sched: scoreboard bench; stimulus queues expected strobes, a forked monitor pops and compares them.
module tb_sweep_sched;
   localparam int EH = 4;
   localparam int PW = 0, EN = 1, MS = 2, DN = 3;
   logic clk = 0, rstn = 1, cfg_wen = 0, start = 0, abort = 0, meas_done = 0;
   logic [31:0] cfg_start_fword = 0, cfg_step_fword = 0, cfg_pword = 0, cfg_amp = 0;
   logic [15:0] cfg_points = 0;
   logic [23:0] cfg_settle = 0;
   logic param_wen, direct_en, meas_start, busy, done;
   logic [31:0] direct_fword, direct_pword, direct_amp;
   logic [15:0] point_idx;
   typedef struct {int kind; int at; logic [31:0] fw; logic [15:0] idx;} ev_t;
   ev_t exp_q[$];
   int cyc = 0, t0 = 0, n_cmp = 0, n_err = 0;
   logic [31:0] x_pw = 0, x_amp = 0;
   bit ok;

   sweep_sched #(.EN_HOLD(EH), .SETTLE_W(24)) dut (
      .clk(clk), .rstn(rstn), .cfg_wen(cfg_wen), .cfg_start_fword(cfg_start_fword),
      .cfg_step_fword(cfg_step_fword), .cfg_points(cfg_points), .cfg_pword(cfg_pword),
      .cfg_amp(cfg_amp), .cfg_settle(cfg_settle), .start(start), .abort(abort),
      .meas_done(meas_done), .param_wen(param_wen), .direct_fword(direct_fword),
      .direct_pword(direct_pword), .direct_amp(direct_amp), .direct_en(direct_en),
      .meas_start(meas_start), .point_idx(point_idx), .busy(busy), .done(done));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic string kname(int k);
      return k == PW ? "param_wen" : k == EN ? "direct_en_fall" : k == MS ? "meas_start" : "done";
   endfunction

   task automatic check(string nm, logic [127:0] got, logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", nm, got, exp);
      end
   endtask

   task automatic push(int k, int at, logic [31:0] fw, logic [15:0] idx);
      ev_t e;
      e.kind = k; e.at = at; e.fw = fw; e.idx = idx;
      exp_q.push_back(e);
   endtask

   // expected strobe timeline from the cycle accounting: param_wen at 1, direct_en 2..EH+1, meas_start at EH+settle+2
   task automatic push_sweep(logic [31:0] st, logic [31:0] sp, int n, int se, int resp);
      int b = 1, ms;
      if (n == 0) push(DN, 0, 0, 0);
      for (int i = 0; i < n; i++) begin
         push(PW, b, st + sp * 32'(i), 16'(i));
         push(EN, b + EH + 1, 0, 0);
         ms = b + EH + se + 1;
         push(MS, ms, 0, 0);
         if (i == n - 1) push(DN, ms + resp + 2, 0, 0);
         else b = ms + resp + 3;
      end
   endtask

   task automatic chk_ev(int k, int en_len);
      ev_t e;
      int rel = cyc - t0;
      bit good;
      n_cmp++;
      if (exp_q.size() == 0) begin
         n_err++;
         $display("FAIL event: got %s at cycle %0d fword=%0h idx=%0d, required no event", kname(k), rel, direct_fword, point_idx);
      end else begin
         e = exp_q.pop_front();
         good = e.kind == k && e.at == rel;
         if (k == PW) good = good && direct_fword == e.fw && point_idx == e.idx && direct_pword == x_pw && direct_amp == x_amp;
         if (k == EN) good = good && en_len == EH;
         if (k == DN) good = good && !busy;
         if (!good) begin
            n_err++;
            $display("FAIL event: got %s at cycle %0d fword=%0h idx=%0d pword=%0h amp=%0h en_len=%0d busy=%0b, required %s at cycle %0d fword=%0h idx=%0d pword=%0h amp=%0h en_len=%0d busy=0",
                     kname(k), rel, direct_fword, point_idx, direct_pword, direct_amp, en_len, busy,
                     kname(e.kind), e.at, e.fw, e.idx, x_pw, x_amp, EH);
         end
      end
   endtask

   task automatic set_cfg(logic [31:0] st, logic [31:0] sp, logic [15:0] n, logic [23:0] se, logic [31:0] pw, logic [31:0] amp);
      cfg_start_fword = st; cfg_step_fword = sp; cfg_points = n; cfg_settle = se;
      cfg_pword = pw; cfg_amp = amp; x_pw = pw; x_amp = amp;
   endtask

   task automatic cfg_pulse();
      @(posedge clk); #1 cfg_wen = 1;
      @(posedge clk); #1 cfg_wen = 0;
   endtask

   task automatic go(bit w);
      @(posedge clk); #1 start = 1; cfg_wen = w; t0 = cyc + 1;
      @(posedge clk); #1 start = 0; cfg_wen = 0;
   endtask

   task automatic wait_ms(output bit seen);
      int k = 0;
      seen = 0;
      while (k < 3000 && !seen) begin
         @(negedge clk);
         seen = meas_start;
         k++;
      end
      check("meas_start_wait", 128'(seen), 128'd1);
   endtask

   task automatic meas_resp(int n, int resp);
      bit seen;
      for (int i = 0; i < n; i++) begin
         wait_ms(seen);
         if (!seen) return;
         repeat (resp) @(posedge clk);
         #1 meas_done = 1;
         @(posedge clk); #1 meas_done = 0;
      end
   endtask

   task automatic drain();
      int k = 0;
      while (exp_q.size() != 0 && k < 3000) begin
         @(negedge clk);
         k++;
      end
      check("events_outstanding", 128'(exp_q.size()), 128'd0);
      exp_q.delete();
      repeat (4) @(posedge clk);
      #1;
   endtask

   initial begin
      fork
         begin
            logic en_prev = 0;
            int en_len = 0;
            forever begin
               @(negedge clk);
               if (rstn) begin
                  if (param_wen) chk_ev(PW, en_len);
                  if (en_prev && !direct_en) chk_ev(EN, en_len);
                  if (meas_start) chk_ev(MS, en_len);
                  if (done) chk_ev(DN, en_len);
               end
               en_len = direct_en ? en_len + 1 : 0;
               en_prev = direct_en;
            end
         end
      join_none
      #2 rstn = 0;
      #20 check("reset_outputs", 128'({param_wen, direct_en, meas_start, busy, done, point_idx, direct_fword, direct_pword, direct_amp}), 128'd0);
      @(posedge clk); #1 rstn = 1;
      // basic sweep
      set_cfg(32'h1000, 32'h100, 3, 5, 32'hA5A5_0001, 32'h0000_3FFF);
      cfg_pulse();
      push_sweep(32'h1000, 32'h100, 3, 5, 3);
      go(0);
      meas_resp(3, 3);
      drain();
      check("t1_busy_idle", 128'(busy), 128'd0);
      check("t1_idx_hold", 128'(point_idx), 128'd2);
      check("t1_fword_hold", 128'(direct_fword), 128'h1200);
      // zero points
      set_cfg(32'h7777, 32'h1, 0, 5, 32'h11, 32'h22);
      cfg_pulse();
      push_sweep(32'h7777, 32'h1, 0, 5, 3);
      go(0);
      drain();
      check("t2_busy_idle", 128'(busy), 128'd0);
      check("t2_fword_hold", 128'(direct_fword), 128'h1200);
      // wrap-around, with cfg_wen and start issued while busy
      set_cfg(32'hFFFF_FF00, 32'h200, 2, 5, 32'hDEAD_BEEF, 32'h0123_4567);
      cfg_pulse();
      push_sweep(32'hFFFF_FF00, 32'h200, 2, 5, 3);
      go(0);
      repeat (3) @(posedge clk);
      #1 cfg_start_fword = 32'h1234_5678; cfg_points = 7; cfg_settle = 0; cfg_pword = 32'h9; cfg_wen = 1; start = 1;
      @(posedge clk); #1 cfg_wen = 0; start = 0;
      meas_resp(2, 3);
      drain();
      check("t3_wrapped_fword", 128'(direct_fword), 128'h100);
      // abort together with start in IDLE
      @(posedge clk); #1 abort = 1; start = 1;
      @(posedge clk); #1 abort = 0; start = 0;
      repeat (4) @(posedge clk);
      #1 check("abort_start_busy", 128'(busy), 128'd0);
      check("abort_start_idx", 128'(point_idx), 128'd1);
      // abort during SETTLE, late meas_done, restart with cfg captured alongside start
      set_cfg(32'h4000, 32'h10, 2, 1000, 32'h5, 32'h6);
      cfg_pulse();
      push(PW, 1, 32'h4000, 0);
      push(EN, EH + 2, 0, 0);
      go(0);
      repeat (8) @(posedge clk);
      #1 abort = 1;
      @(posedge clk); #1 abort = 0;
      check("t4_busy_after_abort", 128'(busy), 128'd0);
      repeat (2) @(posedge clk);
      #1 meas_done = 1;
      @(posedge clk); #1 meas_done = 0;
      repeat (5) @(posedge clk);
      #1 check("t4_late_done_busy", 128'(busy), 128'd0);
      drain();
      set_cfg(32'h4000, 32'h10, 2, 2, 32'h5, 32'h6);
      push_sweep(32'h4000, 32'h10, 2, 2, 3);
      go(1);
      meas_resp(2, 3);
      drain();
      // settle 0 with a stray meas_done during LOAD/APPLY
      set_cfg(32'h8000, 32'h8, 2, 0, 32'h77, 32'h88);
      cfg_pulse();
      push_sweep(32'h8000, 32'h8, 2, 0, 3);
      go(0);
      meas_done = 1;
      repeat (6) @(posedge clk);
      #1 meas_done = 0;
      meas_resp(2, 3);
      drain();
      // asynchronous reset while in MEASURE
      set_cfg(32'h9000, 32'h1, 2, 3, 32'hAB, 32'hCD);
      cfg_pulse();
      push(PW, 1, 32'h9000, 0);
      push(EN, EH + 2, 0, 0);
      push(MS, EH + 5, 0, 0);
      go(0);
      wait_ms(ok);
      #2 rstn = 0;
      #1 check("async_reset_outputs", 128'({param_wen, direct_en, meas_start, busy, done, point_idx, direct_fword, direct_pword, direct_amp}), 128'd0);
      check("async_reset_events", 128'(exp_q.size()), 128'd0);
      exp_q.delete();
      @(posedge clk); #1 rstn = 1;
      repeat (3) @(posedge clk);
      #1 check("post_reset_busy", 128'(busy), 128'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
